// File: rtl/xgmii_tx_scheduler.sv
// Splits buffered 64-bit MAC words into low/high 32-bit XGMII beats for the PCS.
// Inserts idle blocks at word boundaries when no word is ready and honours gearbox pause.
module xgmii_tx_scheduler #(
  parameter int FIFO_DEPTH     = 2,
  parameter int IDLE_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [63:0]               s_txd,
  input  logic [7:0]                s_txc,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [31:0]               o_xgmii_txd,
  output logic [3:0]                o_xgmii_txc,
  output logic                      o_xgmii_valid,
  input  logic                      i_xgmii_pause,
  output logic [IDLE_CNT_WIDTH-1:0] o_idle_words,
  output logic                      o_pause_err
);

  // state | meaning
  // PH_LO | at a 64-bit word boundary; next beat is a low half, idle, or a pause gap
  // PH_HI | low half sent; next beat is the latched high half
  typedef enum logic {PH_LO, PH_HI} phase_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [31:0] IDLE_D = 32'h0707_0707;
  localparam logic [3:0]  IDLE_C = 4'hF;

  logic [71:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, empty;
  logic [71:0]   rd_word;

  phase_t        state, state_next;
  logic [31:0]   hi_d, hi_d_next, txd_next;
  logic [3:0]    hi_c, hi_c_next, txc_next;
  logic          valid_next, idle_inc, err_set;

  assign push       = s_valid & s_ready;
  assign empty      = (count == '0);
  assign rd_word    = mem[rd_ptr];
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {s_txc, s_txd};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      s_ready <= (count_next < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    state_next = state;
    hi_d_next  = hi_d;
    hi_c_next  = hi_c;
    txd_next   = 32'h0;
    txc_next   = 4'h0;
    valid_next = 1'b0;
    idle_inc   = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    case (state)
      PH_LO: begin
        if (i_xgmii_pause) begin
          state_next = PH_LO;
        end else if (i_enable && !empty) begin
          pop        = 1'b1;
          txd_next   = rd_word[31:0];
          txc_next   = rd_word[67:64];
          hi_d_next  = rd_word[63:32];
          hi_c_next  = rd_word[71:68];
          valid_next = 1'b1;
          state_next = PH_HI;
        end else begin
          txd_next   = IDLE_D;
          txc_next   = IDLE_C;
          hi_d_next  = IDLE_D;
          hi_c_next  = IDLE_C;
          valid_next = 1'b1;
          idle_inc   = 1'b1;
          state_next = PH_HI;
        end
      end
      default: begin
        // A pause here cannot split the block, so the high half still goes out.
        txd_next   = hi_d;
        txc_next   = hi_c;
        valid_next = 1'b1;
        err_set    = i_xgmii_pause;
        state_next = PH_LO;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= PH_LO;
      hi_d          <= 32'h0;
      hi_c          <= 4'h0;
      o_xgmii_txd   <= 32'h0;
      o_xgmii_txc   <= 4'h0;
      o_xgmii_valid <= 1'b0;
      o_idle_words  <= '0;
      o_pause_err   <= 1'b0;
    end else begin
      state         <= state_next;
      hi_d          <= hi_d_next;
      hi_c          <= hi_c_next;
      o_xgmii_txd   <= txd_next;
      o_xgmii_txc   <= txc_next;
      o_xgmii_valid <= valid_next;
      if (idle_inc && (o_idle_words != '1)) o_idle_words <= o_idle_words + IDLE_CNT_WIDTH'(1);
      if (err_set) o_pause_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed and random stimulus for xgmii_tx_scheduler, checked against a
// queue-based reference model of the word-to-beat sequencing rules.
module tb_xgmii_tx_scheduler;
  localparam int DEPTH = 2;
  localparam int ICW   = 4;
  localparam int ISAT  = (1 << ICW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [63:0]    txd;
  logic [7:0]     txc;
  logic           vld;
  logic           rdy;
  logic [31:0]    x_txd;
  logic [3:0]     x_txc;
  logic           x_valid;
  logic           pz;
  logic [ICW-1:0] idle_words;
  logic           perr;

  xgmii_tx_scheduler #(.FIFO_DEPTH(DEPTH), .IDLE_CNT_WIDTH(ICW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
    .s_txd(txd), .s_txc(txc), .s_valid(vld), .s_ready(rdy),
    .o_xgmii_txd(x_txd), .o_xgmii_txc(x_txc), .o_xgmii_valid(x_valid),
    .i_xgmii_pause(pz), .o_idle_words(idle_words), .o_pause_err(perr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: accepted words waiting, plus the pending high half of the word in flight.
  logic [71:0] mq[$];
  bit          m_mid;
  logic [31:0] m_hd, m_txd;
  logic [3:0]  m_hc, m_txc;
  bit          m_valid, m_ready, m_err;
  int          m_idle;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mid = 0; m_hd = '0; m_hc = '0;
    m_txd = '0; m_txc = '0; m_valid = 0;
    m_ready = 0; m_err = 0; m_idle = 0;
  endtask

  task automatic model_edge();
    logic [71:0] w;
    if (!m_mid) begin
      if (pz) begin
        m_valid = 0;
      end else if (en && mq.size() > 0) begin
        w = mq.pop_front();
        m_valid = 1; m_txd = w[31:0]; m_txc = w[67:64];
        m_hd = w[63:32]; m_hc = w[71:68]; m_mid = 1;
      end else begin
        m_valid = 1; m_txd = 32'h0707_0707; m_txc = 4'hF;
        m_hd = 32'h0707_0707; m_hc = 4'hF; m_mid = 1;
        if (m_idle < ISAT) m_idle++;
      end
    end else begin
      m_valid = 1; m_txd = m_hd; m_txc = m_hc; m_mid = 0;
      if (pz) m_err = 1;
    end
    if (vld && m_ready) mq.push_back({txc, txd});
    m_ready = (mq.size() < DEPTH);
  endtask

  task automatic compare_all(string tag);
    check({tag, ".s_ready"}, 64'(rdy), 64'(m_ready));
    check({tag, ".valid"}, 64'(x_valid), 64'(m_valid));
    if (m_valid) begin
      check({tag, ".txd"}, 64'(x_txd), 64'(m_txd));
      check({tag, ".txc"}, 64'(x_txc), 64'(m_txc));
    end
    check({tag, ".idle_words"}, 64'(idle_words), 64'(m_idle));
    check({tag, ".pause_err"}, 64'(perr), 64'(m_err));
  endtask

  task automatic step(string tag, bit e, bit p, bit v, logic [63:0] d, logic [7:0] c);
    en = e; pz = p; vld = v; txd = d; txc = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic reset_check(string tag);
    check({tag, ".s_ready"}, 64'(rdy), 64'(0));
    check({tag, ".valid"}, 64'(x_valid), 64'(0));
    check({tag, ".txd"}, 64'(x_txd), 64'(0));
    check({tag, ".txc"}, 64'(x_txc), 64'(0));
    check({tag, ".idle_words"}, 64'(idle_words), 64'(0));
    check({tag, ".pause_err"}, 64'(perr), 64'(0));
  endtask

  // Asserted away from the clock edge to exercise the asynchronous path.
  task automatic apply_reset(string tag);
    #2;
    rst_n = 1'b0;
    vld = 0;
    model_reset();
    #1;
    reset_check({tag, ".async"});
    @(posedge clk);
    #1;
    reset_check({tag, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic push_word(string tag, bit e, logic [63:0] d, logic [7:0] c);
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      done = m_ready;
      step(tag, e, 0, 1, d, c);
    end
    check({tag, ".accept_timeout"}, 64'(done), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; pz = 1'b0; vld = 1'b0; txd = '0; txc = '0;
    model_reset();
    #12;
    reset_check("por");
    rst_n = 1'b1;

    // Idle alternation after reset release
    for (int i = 0; i < 6; i++) step("idle", 1, 0, 0, '0, '0);

    // Single word latency into an empty FIFO at a boundary
    if (m_mid == 0) step("align", 1, 0, 0, '0, '0);
    step("push1", 1, 0, 1, 64'h1111_1111_2222_2222, 8'h00);
    step("w1lo", 1, 0, 0, '0, '0);
    check("w1lo.const", 64'(x_txd), 64'h2222_2222);
    step("w1hi", 1, 0, 0, '0, '0);
    check("w1hi.const", 64'(x_txd), 64'h1111_1111);
    check("w1hi.ctl", 64'(x_txc), 64'h0);

    // Back-to-back five words
    for (int i = 0; i < 5; i++)
      push_word("b2b", 1, {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}, 8'(i * 17));
    for (int i = 0; i < 8; i++) step("b2b_drain", 1, 0, 0, '0, '0);

    // Pause for one cycle between two queued words
    push_word("pq", 0, 64'hC1C1_C1C1_D1D1_D1D1, 8'h12);
    push_word("pq", 0, 64'hC2C2_C2C2_D2D2_D2D2, 8'h34);
    for (int i = 0; i < 4 && m_mid == 1; i++) step("pq_align", 0, 0, 0, '0, '0);
    step("pq_w1lo", 1, 0, 0, '0, '0);
    step("pq_w1hi", 1, 0, 0, '0, '0);
    step("pq_gap", 1, 1, 0, '0, '0);
    check("pq_gap.const", 64'(x_valid), 64'h0);
    step("pq_w2lo", 1, 0, 0, '0, '0);
    step("pq_w2hi", 1, 0, 0, '0, '0);
    check("pq.no_err", 64'(perr), 64'h0);

    // Pause during the high beat
    push_word("ph", 1, 64'hE0E0_E0E0_F0F0_F0F0, 8'hF0);
    for (int i = 0; i < 4 && m_mid == 0; i++) step("ph_align", 1, 0, 0, '0, '0);
    step("ph_hi", 1, 1, 0, '0, '0);
    check("ph.err_const", 64'(perr), 64'h1);
    for (int i = 0; i < 4; i++) step("ph_after", 1, 0, 0, '0, '0);

    // Drop enable with two words queued, then reset mid-word
    push_word("dis", 0, 64'h5555_5555_6666_6666, 8'h0F);
    push_word("dis", 0, 64'h7777_7777_8888_8888, 8'hF0);
    for (int i = 0; i < 3; i++) step("dis_idle", 0, 0, 0, '0, '0);
    if (m_mid == 0) step("dis_align", 0, 0, 0, '0, '0);
    apply_reset("rst_mid");
    for (int i = 0; i < 8; i++) step("post_rst", 1, 0, 0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      if (i == 350) apply_reset("rst_rand");
      step("rand", ($urandom % 8) != 0, ($urandom % 10) == 0, $urandom % 2,
           {$urandom, $urandom}, 8'($urandom));
    end
    for (int i = 0; i < 8; i++) step("rand_drain", 1, 0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
